intersection_phase_scheduler: RTL and testbench
===============================================

# intersection_phase_scheduler

Cycle-timed phase scheduler for a two-street intersection; it drives the street A and street B light encodings. It shares the crossing between two competing streets and their pedestrian-button requesters. It enforces minimum and maximum green, yellow clearance and an all-red interval. A parade/hold input freezes the active green. It sits upstream of the lamp drivers and alongside the parade-mode logic, which drives `hold`.

## Interface
- MIN_GREEN, 4, minimum green dwell in cycles (≥1)
- MAX_GREEN, 8, maximum green dwell when the cross street has demand (≥ MIN_GREEN)
- YELLOW_TIME, 2, yellow dwell in cycles (≥1)
- CNT_W, 4, dwell timer width; must hold MAX_GREEN-1 and YELLOW_TIME-1

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- Ta  in  1  street A vehicle sensor, 1 = traffic present
- Tb  in  1  street B vehicle sensor, 1 = traffic present
- Pa  in  1  street A pedestrian button, 1-cycle pulse or level
- Pb  in  1  street B pedestrian button
- hold  in  1  parade hold; freezes the current green phase
- La  out  3  street A light, one-hot: 001 green, 010 yellow, 100 red
- Lb  out  3  street B light, same encoding
- walk_a  out  1  pedestrian walk for crossing parallel to A
- walk_b  out  1  pedestrian walk for crossing parallel to B
- phase  out  3  state code: 0 A_GRN, 1 A_YEL, 2 AR_AB, 3 B_GRN, 4 B_YEL, 5 AR_BA

## Operation
- Registers: state, dwell timer `tmr`, pending requests `req_a`/`req_b`, and walk grants `wg_a`/`wg_b`. All outputs decode from registers.
- `tmr` clears on every state entry and otherwise increments, saturating at MAX_GREEN-1.
- Lights by phase:
  - A_GRN: La=001, Lb=100
  - A_YEL: La=010, Lb=100
  - AR_AB and AR_BA: both 100
  - B_GRN: La=100, Lb=001
  - B_YEL: La=100, Lb=010
- Demand definitions: dem_b = Tb | req_b; dem_a = Ta | req_a.
- A_GRN → A_YEL when all of the following hold:
  - hold=0
  - tmr ≥ MIN_GREEN-1
  - dem_b=1
  - Ta=0 or tmr = MAX_GREEN-1
- With no dem_b, A_GRN is held indefinitely. B_GRN → B_YEL is symmetric, with A and B swapped.
- A_YEL → AR_AB when tmr = YELLOW_TIME-1. AR_AB → B_GRN after exactly 1 cycle. The B side is symmetric: B_YEL → AR_BA → A_GRN.
- hold is honoured only in the green states. In yellow and all-red states it is ignored, so clearance always completes.
- Requests:
  - Pa=1 sets req_a in any state except A_GRN; in A_GRN it is ignored. Pb/req_b is symmetric.
  - On entry to A_GRN: wg_a ← req_a | Pa, and req_a ← 0. Same for B.
- walk_a = (state=A_GRN) & wg_a & (tmr < MIN_GREEN). walk_b is symmetric. wg_x clears on leaving its green.
- Simultaneous Pa and A_GRN entry: the press is served by that same entry and is not left pending.
- Unused state codes 6 and 7 recover to A_GRN on the next edge, with lights all red while in them.

## Timing
- Reset (asynchronous, immediate) gives:
  - state=A_GRN, tmr=0, req_a=req_b=0, wg_a=wg_b=0
  - La=001, Lb=100, walk_a=walk_b=0, phase=0
- Reset asserted mid-phase, including during yellow, forces the reset values immediately, with no clearance sequence. Requests are lost.
- Input-to-output latency is 1 cycle. An input sampled at edge n affects state and outputs after edge n.
- Minimum A green is MIN_GREEN cycles. The shortest full A→B changeover is MIN_GREEN + YELLOW_TIME + 1 cycles from A_GRN entry to B_GRN entry.
- The timer never wraps; saturation is mandatory.

## Test plan
- Reset, then release with Ta=0, Tb=1 (defaults) → La=001 for 4 cycles, 010 for 2, then 100. Lb=100 until the 7th edge after release, then Lb=001 and phase=3.
- Ta=1, Tb=1 held → A green lasts exactly 8 cycles (MAX_GREEN), then A_YEL. B green also lasts 8, and the sequence alternates indefinitely.
- Ta=1, Tb=0, then a 1-cycle Pb pulse at cycle 10 → req_b set. The changeover starts at the next tmr=MAX_GREEN-1 point. In B_GRN, walk_b=1 for exactly 4 cycles and req_b=0.
- hold=1 asserted during B_GRN with Ta=1 for 20 cycles → Lb stays 001 for the full 20 cycles plus dwell. Asserting hold during A_YEL does not stop the yellow→all-red→B_GRN progression.
- Pa pulse in the same cycle as AR_BA → A_GRN entry → wg_a=1, walk_a=1 for 4 cycles, and req_a remains 0 afterwards.
- rst pulse mid-B_YEL → La=001, Lb=100, phase=0 immediately and asynchronously, and all walks and requests are cleared.

Source files
------------

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - two-street phase scheduler with green/yellow/all-red timing,
// pedestrian requests and parade hold.
module intersection_phase_scheduler #(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 8,
  parameter int YELLOW_TIME = 2,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Pa,
  input  logic       Pb,
  input  logic       hold,
  output logic [2:0] La,
  output logic [2:0] Lb,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_GREEN);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_tmr;
  logic             r_req_a, r_req_b;
  logic             r_wg_a, r_wg_b;
  logic             w_dem_a, w_dem_b;
  logic             w_enter_a, w_enter_b;

  assign w_dem_a   = Ta | r_req_a;
  assign w_dem_b   = Tb | r_req_b;
  assign w_enter_a = (w_next == A_GRN) && (r_state != A_GRN);
  assign w_enter_b = (w_next == B_GRN) && (r_state != B_GRN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      A_GRN: if (!hold && r_tmr >= MIN_M1 && w_dem_b && (!Ta || r_tmr == MAX_M1)) w_next = A_YEL;
      A_YEL: if (r_tmr == YEL_M1) w_next = AR_AB;
      AR_AB: w_next = B_GRN;
      B_GRN: if (!hold && r_tmr >= MIN_M1 && w_dem_a && (!Tb || r_tmr == MAX_M1)) w_next = B_YEL;
      B_YEL: if (r_tmr == YEL_M1) w_next = AR_BA;
      AR_BA: w_next = A_GRN;
      default: w_next = A_GRN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= A_GRN;
      r_tmr   <= '0;
      r_req_a <= 1'b0;
      r_req_b <= 1'b0;
      r_wg_a  <= 1'b0;
      r_wg_b  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_tmr <= '0;
      else if (r_tmr != MAX_M1) r_tmr <= r_tmr + CNT_W'(1);

      // A press coinciding with green entry is folded into the grant, never left pending.
      if (w_enter_a) begin
        r_wg_a  <= r_req_a | Pa;
        r_req_a <= 1'b0;
      end else begin
        if (r_state != A_GRN && Pa) r_req_a <= 1'b1;
        if (w_next != A_GRN) r_wg_a <= 1'b0;
      end

      if (w_enter_b) begin
        r_wg_b  <= r_req_b | Pb;
        r_req_b <= 1'b0;
      end else begin
        if (r_state != B_GRN && Pb) r_req_b <= 1'b1;
        if (w_next != B_GRN) r_wg_b <= 1'b0;
      end
    end
  end

  always_comb begin
    La = 3'b100;
    Lb = 3'b100;
    case (r_state)
      A_GRN: La = 3'b001;
      A_YEL: La = 3'b010;
      B_GRN: Lb = 3'b001;
      B_YEL: Lb = 3'b010;
      default: ;
    endcase
  end

  assign walk_a = (r_state == A_GRN) && r_wg_a && (r_tmr < MIN_C);
  assign walk_b = (r_state == B_GRN) && r_wg_b && (r_tmr < MIN_C);
  assign phase  = r_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - self-checking bench for intersection_phase_scheduler.
module tb_intersection_phase_scheduler;
  localparam int MIN = 4;
  localparam int MAX = 8;
  localparam int YEL = 2;

  logic       clk = 1'b0;
  logic       rst, Ta, Tb, Pa, Pb, hold;
  logic [2:0] La, Lb, phase;
  logic       walk_a, walk_b;

  int n_checks = 0;
  int n_fail   = 0;

  intersection_phase_scheduler #(
    .MIN_GREEN(MIN), .MAX_GREEN(MAX), .YELLOW_TIME(YEL), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .Ta(Ta), .Tb(Tb), .Pa(Pa), .Pb(Pb), .hold(hold),
    .La(La), .Lb(Lb), .walk_a(walk_a), .walk_b(walk_b), .phase(phase)
  );

  always #5 clk = ~clk;

  // Model: phase number, cycles spent in the phase (unbounded), pending presses, walk grants.
  int m_ph    = 0;
  int m_cnt   = 0;
  bit m_req_a = 0, m_req_b = 0, m_wg_a = 0, m_wg_b = 0;

  function automatic int light_a(input int ph);
    return (ph == 0) ? 1 : (ph == 1) ? 2 : 4;
  endfunction

  function automatic int light_b(input int ph);
    return (ph == 3) ? 1 : (ph == 4) ? 2 : 4;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int nxt;
    bit dem_a, dem_b;
    if (rst) begin
      m_ph = 0; m_cnt = 0;
      m_req_a = 0; m_req_b = 0; m_wg_a = 0; m_wg_b = 0;
    end else begin
      dem_a = Ta | m_req_a;
      dem_b = Tb | m_req_b;
      nxt = m_ph;
      case (m_ph)
        0: if (!hold && m_cnt + 1 >= MIN && dem_b && (!Ta || m_cnt + 1 >= MAX)) nxt = 1;
        1: if (m_cnt + 1 >= YEL) nxt = 2;
        2: nxt = 3;
        3: if (!hold && m_cnt + 1 >= MIN && dem_a && (!Tb || m_cnt + 1 >= MAX)) nxt = 4;
        4: if (m_cnt + 1 >= YEL) nxt = 5;
        default: nxt = 0;
      endcase
      if (nxt == 0 && m_ph != 0) begin
        m_wg_a = m_req_a | Pa; m_req_a = 0;
      end else begin
        if (m_ph != 0 && Pa) m_req_a = 1;
        if (nxt != 0) m_wg_a = 0;
      end
      if (nxt == 3 && m_ph != 3) begin
        m_wg_b = m_req_b | Pb; m_req_b = 0;
      end else begin
        if (m_ph != 3 && Pb) m_req_b = 1;
        if (nxt != 3) m_wg_b = 0;
      end
      m_cnt = (nxt != m_ph) ? 0 : m_cnt + 1;
      m_ph  = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_La", La, light_a(m_ph));
      chk("model_Lb", Lb, light_b(m_ph));
      chk("model_phase", phase, m_ph);
      chk("model_walk_a", walk_a, (m_ph == 0 && m_wg_a && m_cnt < MIN) ? 1 : 0);
      chk("model_walk_b", walk_b, (m_ph == 3 && m_wg_b && m_cnt < MIN) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ph(input int p, input string name);
    int n = 0;
    while (phase !== p && n < 60) begin
      step();
      n++;
    end
    chk(name, phase, p);
  endtask

  task automatic count_ph(input int p, input int exp, input string name);
    int n = 0;
    wait_ph(p, name);
    while (phase === p && n < 60) begin
      n++;
      step();
    end
    chk(name, n, exp);
  endtask

  task automatic count_walk_a(input int exp, input string name);
    int nw = 0;
    int k  = 0;
    wait_ph(0, name);
    while (phase === 0 && k < 60) begin
      nw += int'(walk_a);
      step();
      k++;
    end
    chk(name, nw, exp);
  endtask

  int exp_ph[7] = '{0, 0, 0, 1, 1, 2, 3};
  int exp_la[7] = '{1, 1, 1, 2, 2, 4, 4};
  int exp_hy[3] = '{1, 2, 3};

  initial begin
    int nw;
    Ta = 0; Tb = 1; Pa = 0; Pb = 0; hold = 0; rst = 0;
    #1 rst = 1;
    #2;
    chk("reset_La", La, 1);
    chk("reset_Lb", Lb, 4);
    chk("reset_phase", phase, 0);
    chk("reset_walk_a", walk_a, 0);
    chk("reset_walk_b", walk_b, 0);
    step();
    rst = 0;

    // Shortest changeover with only B traffic
    for (int i = 0; i < 7; i++) begin
      step();
      chk("startup_phase", phase, exp_ph[i]);
      chk("startup_La", La, exp_la[i]);
    end

    // Both streets busy: max green each way
    Ta = 1; Tb = 1;
    count_ph(0, 8, "max_green_a");
    count_ph(3, 8, "max_green_b");

    // Pedestrian request on B while A holds indefinitely
    Ta = 1; Tb = 0;
    wait_ph(0, "reach_a_grn");
    repeat (10) step();
    Pb = 1; step(); Pb = 0;
    chk("pb_no_immediate", phase, 0);
    step();
    chk("pb_changeover", phase, 1);
    wait_ph(3, "reach_b_grn");
    hold = 1;
    nw = int'(walk_b);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_lb_green", Lb, 1);
      nw += int'(walk_b);
    end
    chk("walk_b_cycles", nw, 4);
    hold = 0;
    step();
    chk("hold_release", phase, 4);

    // Hold during yellow is ignored; hold in the following green freezes it
    Tb = 1;
    wait_ph(1, "reach_a_yel");
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_in_yellow", phase, exp_hy[i]);
    end
    repeat (10) step();
    chk("hold_freeze_b", phase, 3);
    hold = 0;

    // Press coinciding with A green entry
    wait_ph(5, "reach_ar_ba");
    Pa = 1; step(); Pa = 0;
    chk("pa_entry_phase", phase, 0);
    count_walk_a(4, "pa_entry_walk");
    count_walk_a(0, "req_a_not_pending");
    wait_ph(3, "reach_b_grn2");
    Pa = 1; step(); Pa = 0;
    count_walk_a(4, "req_a_served");

    // Asynchronous reset mid-yellow clears everything
    wait_ph(4, "reach_b_yel");
    Pb = 1; step(); Pb = 0;
    #2 rst = 1;
    #1;
    chk("async_La", La, 1);
    chk("async_Lb", Lb, 4);
    chk("async_phase", phase, 0);
    chk("async_walk_b", walk_b, 0);
    step();
    Ta = 0; Tb = 0;
    rst = 0;
    repeat (12) step();
    chk("req_b_cleared", phase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
